// File: rtl/alu_issue_stage.sv
// Execute-stage front end: decodes an instruction into the ALU's In1/In2/OP,
// then captures the ALU result and branch outcome as a registered record.
module alu_issue_stage #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned OPW  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [XLEN-1:0]   in_rs,
   input  logic [XLEN-1:0]   in_rt,
   output logic [XLEN-1:0]   alu_in1,
   output logic [XLEN-1:0]   alu_in2,
   output logic [OPW-1:0]    alu_op,
   input  logic [XLEN-1:0]   alu_result,
   input  logic              alu_zero,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_result,
   output logic [4:0]        out_rd,
   output logic              out_wen,
   output logic              out_branch,
   output logic              out_taken,
   output logic              out_illegal
);

   localparam int unsigned RW  = 5;
   localparam int unsigned FW  = 6;
   localparam int unsigned IMW = 16;

   localparam logic [OPW-1:0] OP_AND  = OPW'(4'b0000);
   localparam logic [OPW-1:0] OP_OR   = OPW'(4'b0001);
   localparam logic [OPW-1:0] OP_ADD  = OPW'(4'b0010);
   localparam logic [OPW-1:0] OP_SLL  = OPW'(4'b0011);
   localparam logic [OPW-1:0] OP_SRL  = OPW'(4'b0100);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(4'b0110);
   localparam logic [OPW-1:0] OP_SLT  = OPW'(4'b0111);
   localparam logic [OPW-1:0] OP_BNE  = OPW'(4'b1000);
   localparam logic [OPW-1:0] OP_XOR  = OPW'(4'b1011);
   localparam logic [OPW-1:0] OP_NOR  = OPW'(4'b1100);
   localparam logic [OPW-1:0] OP_SLTU = OPW'(4'b1111);

   localparam logic [FW-1:0] OPC_RTYPE = 6'h00;
   localparam logic [FW-1:0] OPC_BEQ   = 6'h04;
   localparam logic [FW-1:0] OPC_BNE   = 6'h05;
   localparam logic [FW-1:0] OPC_ADDI  = 6'h08;
   localparam logic [FW-1:0] OPC_SLTI  = 6'h0A;
   localparam logic [FW-1:0] OPC_SLTIU = 6'h0B;
   localparam logic [FW-1:0] OPC_ANDI  = 6'h0C;
   localparam logic [FW-1:0] OPC_ORI   = 6'h0D;
   localparam logic [FW-1:0] OPC_XORI  = 6'h0E;

   localparam logic [FW-1:0] FN_SLL  = 6'h00;
   localparam logic [FW-1:0] FN_SRL  = 6'h02;
   localparam logic [FW-1:0] FN_ADD  = 6'h20;
   localparam logic [FW-1:0] FN_ADDU = 6'h21;
   localparam logic [FW-1:0] FN_SUB  = 6'h22;
   localparam logic [FW-1:0] FN_SUBU = 6'h23;
   localparam logic [FW-1:0] FN_AND  = 6'h24;
   localparam logic [FW-1:0] FN_OR   = 6'h25;
   localparam logic [FW-1:0] FN_XOR  = 6'h26;
   localparam logic [FW-1:0] FN_NOR  = 6'h27;
   localparam logic [FW-1:0] FN_SLT  = 6'h2A;
   localparam logic [FW-1:0] FN_SLTU = 6'h2B;

   // Instruction fields
   logic [FW-1:0]   opcode;
   logic [FW-1:0]   funct;
   logic [RW-1:0]   f_rt;
   logic [RW-1:0]   f_rd;
   logic [RW-1:0]   shamt;
   logic [IMW-1:0]  imm;
   logic [XLEN-1:0] imm_sext;
   logic [XLEN-1:0] imm_zext;
   logic            unused_rs_field;

   assign opcode          = in_instr[31:26];
   assign f_rt            = in_instr[20:16];
   assign f_rd            = in_instr[15:11];
   assign shamt           = in_instr[10:6];
   assign funct           = in_instr[5:0];
   assign imm             = in_instr[15:0];
   assign imm_sext        = {{(XLEN-IMW){imm[IMW-1]}}, imm};
   assign imm_zext        = XLEN'(imm);
   assign unused_rs_field = ^in_instr[25:21];

   // Decoded issue payload
   logic [OPW-1:0]  d_op;
   logic [XLEN-1:0] d_in1;
   logic [XLEN-1:0] d_in2;
   logic [RW-1:0]   d_rd;
   logic            d_wen;
   logic            d_branch;
   logic            d_bne;
   logic            d_illegal;

   // Issue register (alu_in1/alu_in2/alu_op are its operand fields)
   logic            s0_valid;
   logic [RW-1:0]   s0_rd;
   logic            s0_wen;
   logic            s0_branch;
   logic            s0_bne;
   logic            s0_illegal;

   logic            adv;
   logic            accept;
   logic            branch_taken;

   assign adv          = !out_valid || out_ready;
   assign in_ready     = !s0_valid || adv;
   assign accept       = in_valid && in_ready;
   assign branch_taken = s0_bne ? (alu_result != '0) : alu_zero;

   // Decode opcode/funct into OP code, operand selection and writeback intent
   always_comb begin
      d_op      = OP_AND;
      d_in1     = '0;
      d_in2     = '0;
      d_rd      = '0;
      d_wen     = 1'b0;
      d_branch  = 1'b0;
      d_bne     = 1'b0;
      d_illegal = 1'b0;
      case (opcode)
         OPC_RTYPE: begin
            d_in1 = in_rs;
            d_in2 = in_rt;
            d_rd  = f_rd;
            d_wen = 1'b1;
            case (funct)
               FN_ADD, FN_ADDU: d_op = OP_ADD;
               FN_SUB, FN_SUBU: d_op = OP_SUB;
               FN_AND:          d_op = OP_AND;
               FN_OR:           d_op = OP_OR;
               FN_XOR:          d_op = OP_XOR;
               FN_NOR:          d_op = OP_NOR;
               FN_SLT:          d_op = OP_SLT;
               FN_SLTU:         d_op = OP_SLTU;
               FN_SLL: begin
                  d_op  = OP_SLL;
                  d_in1 = in_rt;
                  d_in2 = XLEN'(shamt);
               end
               FN_SRL: begin
                  d_op  = OP_SRL;
                  d_in1 = in_rt;
                  d_in2 = XLEN'(shamt);
               end
               default: d_illegal = 1'b1;
            endcase
         end
         OPC_ADDI, OPC_SLTI, OPC_SLTIU, OPC_ANDI, OPC_ORI, OPC_XORI: begin
            d_in1 = in_rs;
            d_rd  = f_rt;
            d_wen = 1'b1;
            case (opcode)
               OPC_ADDI:  begin d_op = OP_ADD;  d_in2 = imm_sext; end
               OPC_SLTI:  begin d_op = OP_SLT;  d_in2 = imm_sext; end
               OPC_SLTIU: begin d_op = OP_SLTU; d_in2 = imm_sext; end
               OPC_ANDI:  begin d_op = OP_AND;  d_in2 = imm_zext; end
               OPC_ORI:   begin d_op = OP_OR;   d_in2 = imm_zext; end
               default:   begin d_op = OP_XOR;  d_in2 = imm_zext; end
            endcase
         end
         OPC_BEQ: begin
            d_op     = OP_SUB;
            d_in1    = in_rs;
            d_in2    = in_rt;
            d_branch = 1'b1;
         end
         OPC_BNE: begin
            d_op     = OP_BNE;
            d_in1    = in_rs;
            d_in2    = in_rt;
            d_branch = 1'b1;
            d_bne    = 1'b1;
         end
         default: d_illegal = 1'b1;
      endcase
      // Unsupported encodings still flow through, but as an inert record
      if (d_illegal) begin
         d_op     = OP_AND;
         d_in1    = '0;
         d_in2    = '0;
         d_rd     = '0;
         d_wen    = 1'b0;
         d_branch = 1'b0;
         d_bne    = 1'b0;
      end
      if (d_rd == '0) begin
         d_wen = 1'b0;
      end
   end

   // Issue register: loads on accept, empties when its record moves on
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid   <= 1'b0;
         alu_in1    <= '0;
         alu_in2    <= '0;
         alu_op     <= '0;
         s0_rd      <= '0;
         s0_wen     <= 1'b0;
         s0_branch  <= 1'b0;
         s0_bne     <= 1'b0;
         s0_illegal <= 1'b0;
      end else if (accept) begin
         s0_valid   <= 1'b1;
         alu_in1    <= d_in1;
         alu_in2    <= d_in2;
         alu_op     <= d_op;
         s0_rd      <= d_rd;
         s0_wen     <= d_wen;
         s0_branch  <= d_branch;
         s0_bne     <= d_bne;
         s0_illegal <= d_illegal;
      end else if (adv) begin
         s0_valid <= 1'b0;
      end
   end

   // Result register: captures the ALU output and resolves the branch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_rd      <= '0;
         out_wen     <= 1'b0;
         out_branch  <= 1'b0;
         out_taken   <= 1'b0;
         out_illegal <= 1'b0;
      end else if (s0_valid && adv) begin
         out_valid   <= 1'b1;
         out_result  <= alu_result;
         out_rd      <= s0_rd;
         out_wen     <= s0_wen;
         out_branch  <= s0_branch;
         out_taken   <= s0_branch && branch_taken;
         out_illegal <= s0_illegal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: instruction-level reference model feeding a
// scoreboard queue, checked by an independent output monitor.
`timescale 1ns/1ps
module tb_alu_issue_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_rs;
   logic [31:0] in_rt;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic        out_wen;
   logic        out_branch;
   logic        out_taken;
   logic        out_illegal;

   alu_issue_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_rs       (in_rs),
      .in_rt       (in_rt),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_op      (alu_op),
      .alu_result  (alu_result),
      .alu_zero    (alu_zero),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_rd      (out_rd),
      .out_wen     (out_wen),
      .out_branch  (out_branch),
      .out_taken   (out_taken),
      .out_illegal (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU environment; Zero_flag is inverted for OP 1000 so it must be ignored there
   always_comb begin
      alu_result = '0;
      case (alu_op)
         4'b0000: alu_result = alu_in1 & alu_in2;
         4'b0001: alu_result = alu_in1 | alu_in2;
         4'b0010: alu_result = alu_in1 + alu_in2;
         4'b0110: alu_result = alu_in1 - alu_in2;
         4'b1011: alu_result = alu_in1 ^ alu_in2;
         4'b1100: alu_result = ~(alu_in1 | alu_in2);
         4'b0111: alu_result = ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
         4'b1111: alu_result = (alu_in1 < alu_in2) ? 32'd1 : 32'd0;
         4'b0011: alu_result = alu_in1 << alu_in2[4:0];
         4'b0100: alu_result = alu_in1 >> alu_in2[4:0];
         4'b1000: alu_result = alu_in1 - alu_in2;
         default: alu_result = '0;
      endcase
      alu_zero = (alu_op == 4'b1000) ? (alu_result != 0) : (alu_result == 0);
   end

   typedef struct {
      logic [31:0] res;
      logic [31:0] in1;
      logic [31:0] in2;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        wen;
      logic        br;
      logic        tk;
      logic        ill;
   } exp_t;

   exp_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   localparam logic [5:0] RFUN [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                        6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02};
   localparam logic [5:0] IOPC [8]  = '{6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                                        6'h04, 6'h05};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: what each instruction means, computed directly from its semantics
   function automatic exp_t model(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
      exp_t        e;
      logic [31:0] se;
      logic [31:0] ze;
      logic [4:0]  sh;
      e  = '{default: 0};
      se = {{16{i[15]}}, i[15:0]};
      ze = {16'h0, i[15:0]};
      sh = i[10:6];
      e.in1 = rs;
      case (i[31:26])
         6'h00: begin
            e.rd  = i[15:11];
            e.wen = 1'b1;
            e.in2 = rt;
            case (i[5:0])
               6'h20, 6'h21: begin e.op = 4'b0010; e.res = rs + rt; end
               6'h22, 6'h23: begin e.op = 4'b0110; e.res = rs - rt; end
               6'h24: begin e.op = 4'b0000; e.res = rs & rt; end
               6'h25: begin e.op = 4'b0001; e.res = rs | rt; end
               6'h26: begin e.op = 4'b1011; e.res = rs ^ rt; end
               6'h27: begin e.op = 4'b1100; e.res = ~(rs | rt); end
               6'h2A: begin e.op = 4'b0111; e.res = 32'($signed(rs) < $signed(rt)); end
               6'h2B: begin e.op = 4'b1111; e.res = 32'(rs < rt); end
               6'h00: begin e.op = 4'b0011; e.in1 = rt; e.in2 = 32'(sh); e.res = rt << sh; end
               6'h02: begin e.op = 4'b0100; e.in1 = rt; e.in2 = 32'(sh); e.res = rt >> sh; end
               default: e.ill = 1'b1;
            endcase
         end
         6'h08: begin e.op = 4'b0010; e.in2 = se; e.res = rs + se; end
         6'h0A: begin e.op = 4'b0111; e.in2 = se; e.res = 32'($signed(rs) < $signed(se)); end
         6'h0B: begin e.op = 4'b1111; e.in2 = se; e.res = 32'(rs < se); end
         6'h0C: begin e.op = 4'b0000; e.in2 = ze; e.res = rs & ze; end
         6'h0D: begin e.op = 4'b0001; e.in2 = ze; e.res = rs | ze; end
         6'h0E: begin e.op = 4'b1011; e.in2 = ze; e.res = rs ^ ze; end
         6'h04: begin e.op = 4'b0110; e.in2 = rt; e.res = rs - rt; e.br = 1'b1; e.tk = (rs == rt); end
         6'h05: begin e.op = 4'b1000; e.in2 = rt; e.res = rs - rt; e.br = 1'b1; e.tk = (rs != rt); end
         default: e.ill = 1'b1;
      endcase
      if (i[31:26] != 6'h00 && !e.br) begin
         e.rd  = i[20:16];
         e.wen = 1'b1;
      end
      if (e.ill) begin
         e     = '{default: 0};
         e.ill = 1'b1;
      end
      if (e.rd == 5'd0) e.wen = 1'b0;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] i;
      int unsigned k;
      i = $urandom();
      k = $urandom_range(0, 23);
      if (k < 12) begin
         i[31:26] = 6'h00;
         i[5:0]   = RFUN[k];
      end else if (k < 20) begin
         i[31:26] = IOPC[k-12];
      end else if (k < 22) begin
         i[31:26] = (k == 20) ? 6'h3F : 6'h23;
      end else begin
         i[31:26] = 6'h00;
         i[5:0]   = (k == 22) ? 6'h01 : 6'h3F;
      end
      if ($urandom_range(0, 7) == 0) begin
         i[15:11] = 5'd0;
         i[20:16] = 5'd0;
      end
      return i;
   endfunction

   // One cycle of drive, called at posedge+1; reports whether the edge accepted
   task automatic step(input logic v, input logic [31:0] i, input logic [31:0] rs,
                       input logic [31:0] rt, input logic ordy, output logic acc);
      in_valid  = v;
      in_instr  = i;
      in_rs     = rs;
      in_rt     = rt;
      out_ready = ordy;
      @(negedge clk);
      acc = v && in_ready;
      @(posedge clk);
      #1;
      if (acc) q.push_back(model(i, rs, rt));
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                       input logic rnd_ready, input logic ordy);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 100) begin
         step(1'b1, i, rs, rt, rnd_ready ? 1'($urandom_range(0, 1)) : ordy, acc);
         n++;
      end
      if (!acc) chk("send_timeout", 64'(acc), 64'd1);
   endtask

   task automatic idle(input int cycles, input logic ordy);
      logic acc;
      for (int c = 0; c < cycles; c++) step(1'b0, 32'h0, 32'h0, 32'h0, ordy, acc);
   endtask

   // Monitor: pops on every newly presented record, checks hold under backpressure
   logic        pv, pr;
   logic [40:0] p_out;
   logic [31:0] p_in1, p_in2;
   logic [3:0]  p_op;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         pv = 1'b0;
         pr = 1'b0;
      end else begin
         if (out_valid && (!pv || pr)) begin
            if (q.size() == 0) begin
               chk("unexpected_record", 64'(out_result), 64'hDEAD_0000_0000);
            end else begin
               e = q.pop_front();
               chk("result",  64'(out_result),  64'(e.res));
               chk("wen",     64'(out_wen),     64'(e.wen));
               chk("branch",  64'(out_branch),  64'(e.br));
               chk("taken",   64'(out_taken),   64'(e.tk));
               chk("illegal", 64'(out_illegal), 64'(e.ill));
               if (!e.ill && !e.br) chk("rd", 64'(out_rd), 64'(e.rd));
               chk("alu_op",  64'(p_op),  64'(e.op));
               chk("alu_in1", 64'(p_in1), 64'(e.in1));
               chk("alu_in2", 64'(p_in2), 64'(e.in2));
            end
         end
         if (pv && !pr) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_record",
                64'({out_result, out_rd, out_wen, out_branch, out_taken, out_illegal}),
                64'(p_out));
         end
         pv    = out_valid;
         pr    = out_ready;
         p_out = {out_result, out_rd, out_wen, out_branch, out_taken, out_illegal};
         p_in1 = alu_in1;
         p_in2 = alu_in2;
         p_op  = alu_op;
      end
   end

   initial begin
      logic acc;
      int   cnt;
      logic [31:0] rs;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_rs     = '0;
      in_rt     = '0;
      out_ready = 1'b0;
      #1;
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_alu_op",    64'(alu_op),    64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // add rd=3, rs=5, rt=7 and its one-cycle latency
      send({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd5, 32'd7, 1'b0, 1'b1);
      @(negedge clk);
      chk("lat_before", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("lat_after", 64'(out_valid), 64'd1);
      chk("add_result", 64'(out_result), 64'd12);
      @(posedge clk);
      #1;

      send({6'h08, 5'd1, 5'd4, 16'hFFFF}, 32'd1, 32'd0, 1'b0, 1'b1);
      send({6'h0C, 5'd1, 5'd4, 16'hFFFF}, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
      send({6'h04, 5'd1, 5'd2, 16'h0010}, 32'd9, 32'd9, 1'b0, 1'b1);
      send({6'h05, 5'd1, 5'd2, 16'h0010}, 32'd9, 32'd9, 1'b0, 1'b1);
      send({6'h05, 5'd1, 5'd2, 16'h0010}, 32'd9, 32'd4, 1'b0, 1'b1);
      send({6'h3F, 26'h0}, 32'd3, 32'd4, 1'b0, 1'b1);
      send({6'h00, 5'd0, 5'd2, 5'd0, 5'd4, 6'h00}, 32'd0, 32'd3, 1'b0, 1'b1);
      idle(3, 1'b1);

      // Backpressure: four back-to-back with out_ready low for three cycles
      cnt = 0;
      step(1'b1, {6'h00, 5'd1, 5'd2, 5'd5, 5'd0, 6'h20}, 32'd1, 32'd1, 1'b0, acc);
      cnt += int'(acc);
      step(1'b1, {6'h00, 5'd1, 5'd2, 5'd6, 5'd0, 6'h22}, 32'd10, 32'd3, 1'b0, acc);
      cnt += int'(acc);
      step(1'b1, {6'h0D, 5'd1, 5'd7, 16'h00F0}, 32'h0F, 32'd0, 1'b0, acc);
      cnt += int'(acc);
      chk("bp_accepts", 64'(cnt), 64'd2);
      chk("bp_third_blocked", 64'(acc), 64'd0);
      if (!acc) send({6'h0D, 5'd1, 5'd7, 16'h00F0}, 32'h0F, 32'd0, 1'b0, 1'b1);
      send({6'h00, 5'd1, 5'd8, 5'd9, 5'd4, 6'h02}, 32'd0, 32'h8000_0000, 1'b0, 1'b1);
      idle(4, 1'b1);
      chk("bp_drained", 64'(q.size()), 64'd0);

      // Async reset with a record stalled at the output
      send({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25}, 32'd6, 32'd9, 1'b0, 1'b0);
      idle(2, 1'b0);
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_alu_op",    64'(alu_op),    64'd0);
      chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
      chk("mid_rst_alu_in1",   64'(alu_in1),   64'd0);
      q.delete();
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Randomised traffic with random backpressure and bubbles
      for (int t = 0; t < 400; t++) begin
         rs = $urandom();
         if ($urandom_range(0, 3) == 0) rs = 32'($urandom_range(0, 15));
         send(rand_instr(), rs, ($urandom_range(0, 3) == 0) ? rs : $urandom(), 1'b1, 1'b0);
         if ($urandom_range(0, 5) == 0) idle(1, 1'($urandom_range(0, 1)));
      end

      // Drain with a bounded wait
      for (int c = 0; c < 50 && q.size() != 0; c++) idle(1, 1'b1);
      idle(2, 1'b1);
      chk("final_drain", 64'(q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Execute-stage front end that drives the 32-bit ALU's In1/In2/OP interface from a decoded instruction and consumes its result and Zero_flag. It accepts one instruction plus register operands per valid/ready handshake, decodes opcode/funct into the 4-bit ALU OP code, and selects the operands. It captures the ALU result, resolves beq/bne and presents a registered writeback/branch record downstream. Two-stage pipeline (issue register, result register) with full backpressure.

Parameters:
XLEN, 32, datapath width; fixed at 32, other values unsupported.
OPW, 4, ALU OP code width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction/operands valid
in_ready  out  1  stage can accept (combinational)
in_instr  in  32  instruction word
in_rs  in  32  rs register value
in_rt  in  32  rt register value
alu_in1  out  32  to ALU In1 (from issue register)
alu_in2  out  32  to ALU In2 (from issue register)
alu_op  out  4  to ALU OP (from issue register)
alu_result  in  32  from ALU result (combinational)
alu_zero  in  1  from ALU Zero_flag
out_valid  out  1  record valid
out_ready  in  1  downstream accepts
out_result  out  32  captured ALU result
out_rd  out  5  destination register
out_wen  out  1  register write required
out_branch  out  1  record is beq/bne
out_taken  out  1  branch taken
out_illegal  out  1  unsupported encoding

Behaviour:
- Reset (async, rst_n=0): every issue and result register cleared. out_valid=0, out_* =0, alu_in1=alu_in2=0, alu_op=4'b0000. in_ready=1 once reset is asserted, including mid-operation. In-flight records are discarded.
- Handshakes: a transfer occurs when valid&ready are both high at a rising edge.
- adv = !out_valid | out_ready.
- in_ready = !s0_valid | adv.
- s0 loads on an input transfer. Otherwise, if adv, s0_valid is cleared.
- s1 (out_*) loads from s0 when s0_valid&adv. Otherwise, if out_ready, out_valid is cleared.
- While out_valid & !out_ready, all out_* and the issue register hold stable.
- Latency: accepted at edge k, so out_valid=1 after edge k+1. Throughput is 1 per cycle.
- Simultaneous accept at s0 and drain at s1 in the same edge is legal.
- Decode, R-type (opcode 0x00): OP codes by funct:
  - 0x20/0x21 -> 0010, 0x22/0x23 -> 0110
  - 0x24 -> 0000, 0x25 -> 0001, 0x26 -> 1011, 0x27 -> 1100
  - 0x2A -> 0111, 0x2B -> 1111
  - For these: In1=rs, In2=rt.
  - 0x00 sll -> 0011, 0x02 srl -> 0100: In1=rt, In2=zero-extended shamt[10:6].
  - All R-type: rd=instr[15:11], wen=1.
- Decode, I-type: OP codes by opcode:
  - addi 0x08 -> 0010, slti 0x0A -> 0111, sltiu 0x0B -> 1111: In2 = sign-extended imm.
  - andi 0x0C -> 0000, ori 0x0D -> 0001, xori 0x0E -> 1011: In2 = zero-extended imm.
  - In1=rs, rd=instr[20:16], wen=1.
- Branches: beq 0x04 -> 0110, bne 0x05 -> 1000. In1=rs, In2=rt, wen=0, branch=1.
  - beq taken = alu_zero.
  - bne taken = (alu_result != 0). The stage does not use alu_zero for OP 1000.
- Writes to register 0: rd==0 forces wen=0.
- Unsupported opcode/funct: illegal=1, wen=0, branch=0, OP=0000, operands 0. The record still flows through the pipeline.
- Non-branch records: taken=0.
- out_result: captured ALU result for every record, including branches.

Test Plan:
- Reset mid-stream: assert rst_n=0 with out_valid=1 -> out_valid=0, alu_op=0, in_ready=1 immediately (async).
- add rd=3 with rs=5, rt=7, out_ready=1 -> alu_op=0010; out_valid one cycle after accept; out_result=12, out_rd=3, out_wen=1.
- addi with imm=0xFFFF, rs=1 -> alu_in2=0xFFFFFFFF, out_result=0. andi with imm=0xFFFF -> alu_in2=0x0000FFFF.
- Branches:
  - beq rs=rt=9 -> out_taken=1, out_wen=0.
  - bne rs=9, rt=9 -> alu_op=1000, out_taken=0.
  - bne rs=9, rt=4 -> out_taken=1.
- Backpressure: 4 back-to-back instructions with out_ready=0 for 3 cycles -> in_ready drops after 2 accepts, out_* held stable. On release, all 4 records delivered in order, none lost or duplicated.
- Illegal instruction (opcode 0x3F) and sll rd=0 -> out_illegal=1/wen=0 for the first; wen=0 for the second despite valid decode.
